// File: rtl/ex_muldiv_unit_if.sv
// Handshake and result bus between the ID/EX register and the EX-stage mul/div unit.
interface ex_muldiv_unit_if #(
  parameter int unsigned DATA_W = 32
) ();

  logic              md_start;
  logic [2:0]        md_op;
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  // Pipeline side: issues ops, observes status and HI/LO.
  modport master (
    output md_start,
    output md_op,
    output rs_val,
    output rt_val,
    input  busy,
    input  done,
    input  hi,
    input  lo
  );

  // Unit side.
  modport slave (
    input  md_start,
    input  md_op,
    input  rs_val,
    input  rt_val,
    output busy,
    output done,
    output hi,
    output lo
  );

endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers.
// Operands are reduced to magnitudes on issue, iterated one bit per cycle for DATA_W
// cycles, then sign-corrected in a single FIX cycle that writes HI/LO.
// CNT_W must satisfy 2**CNT_W > DATA_W.
module ex_muldiv_unit #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  ex_muldiv_unit_if.slave   md
);

  localparam int unsigned W2 = 2 * DATA_W;

  localparam logic [2:0] OpMult  = 3'b001;
  localparam logic [2:0] OpMultu = 3'b010;
  localparam logic [2:0] OpDiv   = 3'b011;
  localparam logic [2:0] OpDivu  = 3'b100;
  localparam logic [2:0] OpMthi  = 3'b101;
  localparam logic [2:0] OpMtlo  = 3'b110;

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  // MUL: {partial product high, remaining multiplier bits}; DIV: {remainder, dividend/quotient}.
  logic [W2-1:0]     acc_q;
  // Multiplicand magnitude for MUL, divisor magnitude for DIV.
  logic [DATA_W-1:0] opnd_q;
  logic              is_div_q;
  logic              neg_lo_q;  // negate product / quotient in FIX
  logic              neg_hi_q;  // negate remainder in FIX
  logic              busy_q;
  logic              done_q;
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;

  // Issue-time operand conditioning.
  logic              op_signed;
  logic              rs_neg;
  logic              rt_neg;
  logic [DATA_W-1:0] rs_mag;
  logic [DATA_W-1:0] rt_mag;

  // Per-iteration datapath.
  logic [DATA_W:0]   mul_sum;
  logic [W2-1:0]     mul_next;
  logic [DATA_W:0]   div_shift;
  logic [DATA_W:0]   div_diff;
  logic              div_ge;
  logic [W2-1:0]     div_next;
  logic [W2-1:0]     acc_next;

  // Final sign correction.
  logic [W2-1:0]     prod_fix;
  logic [DATA_W-1:0] quo_fix;
  logic [DATA_W-1:0] rem_fix;
  logic [DATA_W-1:0] fix_hi;
  logic [DATA_W-1:0] fix_lo;

  // Magnitudes and signs of the incoming operands.
  always_comb begin
    op_signed = (md.md_op == OpMult) || (md.md_op == OpDiv);
    rs_neg    = op_signed && md.rs_val[DATA_W-1];
    rt_neg    = op_signed && md.rt_val[DATA_W-1];
    rs_mag    = rs_neg ? -md.rs_val : md.rs_val;
    rt_mag    = rt_neg ? -md.rt_val : md.rt_val;
  end

  // One shift-add or restoring shift-subtract step.
  always_comb begin
    mul_sum   = {1'b0, acc_q[W2-1:DATA_W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next  = {mul_sum, acc_q[DATA_W-1:1]};
    div_shift = {acc_q[W2-1:DATA_W], acc_q[DATA_W-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    // Explicit compare so a zero divisor keeps subtracting and yields all-ones / dividend.
    div_ge    = div_shift >= {1'b0, opnd_q};
    div_next  = div_ge ? {div_diff[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1}
                       : {div_shift[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0};
    acc_next  = is_div_q ? div_next : mul_next;
  end

  // Sign-corrected HI/LO values written in FIX.
  always_comb begin
    prod_fix = neg_lo_q ? -acc_q : acc_q;
    quo_fix  = neg_lo_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
    rem_fix  = neg_hi_q ? -acc_q[W2-1:DATA_W] : acc_q[W2-1:DATA_W];
    fix_hi   = is_div_q ? rem_fix : prod_fix[W2-1:DATA_W];
    fix_lo   = is_div_q ? quo_fix : prod_fix[DATA_W-1:0];
  end

  // Control FSM with registered outputs; new requests are only looked at in IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (md.md_start) begin
            unique case (md.md_op)
              OpMult, OpMultu: begin
                acc_q    <= {{DATA_W{1'b0}}, rt_mag};
                opnd_q   <= rs_mag;
                is_div_q <= 1'b0;
                neg_lo_q <= rs_neg ^ rt_neg;
                neg_hi_q <= 1'b0;
                cnt_q    <= '0;
                busy_q   <= 1'b1;
                state_q  <= StCalc;
              end
              OpDiv, OpDivu: begin
                acc_q    <= {{DATA_W{1'b0}}, rs_mag};
                opnd_q   <= rt_mag;
                is_div_q <= 1'b1;
                // Divide by zero must leave LO all ones, so never negate it.
                neg_lo_q <= (rs_neg ^ rt_neg) && (md.rt_val != '0);
                neg_hi_q <= rs_neg;
                cnt_q    <= '0;
                busy_q   <= 1'b1;
                state_q  <= StCalc;
              end
              OpMthi: hi_q <= md.rs_val;
              OpMtlo: lo_q <= md.rs_val;
              default: ;
            endcase
          end
        end
        StCalc: begin
          acc_q <= acc_next;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            state_q <= StFix;
          end
        end
        StFix: begin
          hi_q    <= fix_hi;
          lo_q    <= fix_lo;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign md.busy = busy_q;
  assign md.done = done_q;
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: vector table for arithmetic results plus hand
// sequences for MTHI/MTLO, ignored requests while busy, and mid-operation reset.
module tb_ex_muldiv_unit;

  localparam logic [2:0] OpNone  = 3'b000;
  localparam logic [2:0] OpMult  = 3'b001;
  localparam logic [2:0] OpMultu = 3'b010;
  localparam logic [2:0] OpDiv   = 3'b011;
  localparam logic [2:0] OpDivu  = 3'b100;
  localparam logic [2:0] OpMthi  = 3'b101;
  localparam logic [2:0] OpMtlo  = 3'b110;
  localparam logic [2:0] OpNone7 = 3'b111;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   illegal_cnt;

  ex_muldiv_unit_if #(.DATA_W(32)) bus ();

  ex_muldiv_unit #(
    .DATA_W(32),
    .CNT_W (6)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .md   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Requests issued while busy are illegal in the pipeline; count them.
  always @(posedge clk) begin
    if (reset && bus.md_start && bus.busy) begin
      illegal_cnt <= illegal_cnt + 1;
      $display("note: md_start while busy at %0t", $time);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present one request for exactly one edge; returns #1 after that edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
    @(negedge clk);
    bus.md_start = 1'b1;
    bus.md_op    = op;
    bus.rs_val   = rs;
    bus.rt_val   = rt;
    @(posedge clk);
    #1;
    bus.md_start = 1'b0;
    bus.md_op    = OpNone;
  endtask

  // Wait (bounded) for done; lat counts edges after the start edge.
  task automatic wait_done(input int lat_in, output int lat, output int busy_cyc);
    lat      = lat_in;
    busy_cyc = 0;
    while (!bus.done && lat < 100) begin
      if (bus.busy) busy_cyc++;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  vec_t vecs[13];
  int   lat;
  int   bcyc;
  int   bdummy;

  initial begin
    checks       = 0;
    failures     = 0;
    illegal_cnt  = 0;
    reset        = 1'b0;
    bus.md_start = 1'b0;
    bus.md_op    = OpNone;
    bus.rs_val   = '0;
    bus.rt_val   = '0;

    vecs[0]  = '{OpMult,  32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[1]  = '{OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2]  = '{OpMult,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    vecs[3]  = '{OpDiv,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[4]  = '{OpDivu,  32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003};
    vecs[5]  = '{OpDivu,  32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF};
    vecs[6]  = '{OpDiv,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[7]  = '{OpDiv,   32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003};
    vecs[8]  = '{OpDiv,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[9]  = '{OpDiv,   32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF};
    vecs[10] = '{OpMultu, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};
    vecs[11] = '{OpDivu,  32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF};
    vecs[12] = '{OpMult,  32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0000};

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'b0, bus.busy}, 32'h0);
    check("rst_done", {31'b0, bus.done}, 32'h0);
    check("rst_hi", bus.hi, 32'h0);
    check("rst_lo", bus.lo, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // MTHI / MTLO are single-cycle and never raise busy or done.
    issue(OpMthi, 32'h0000_1234, 32'h0);
    check("mthi_hi", bus.hi, 32'h0000_1234);
    check("mthi_busy", {31'b0, bus.busy}, 32'h0);
    check("mthi_done", {31'b0, bus.done}, 32'h0);
    issue(OpMtlo, 32'h0000_5678, 32'h0);
    check("mtlo_lo", bus.lo, 32'h0000_5678);
    check("mtlo_hi_kept", bus.hi, 32'h0000_1234);

    // No-op encodings leave everything alone.
    issue(OpNone, 32'hDEAD_BEEF, 32'h1);
    issue(OpNone7, 32'hDEAD_BEEF, 32'h1);
    @(posedge clk);
    #1;
    check("nop_busy", {31'b0, bus.busy}, 32'h0);
    check("nop_hi", bus.hi, 32'h0000_1234);
    check("nop_lo", bus.lo, 32'h0000_5678);

    // Arithmetic vectors; each new op lands in the previous op's done cycle.
    for (int i = 0; i < 13; i++) begin
      issue(vecs[i].op, vecs[i].rs, vecs[i].rt);
      check($sformatf("v%0d_done_low", i), {31'b0, bus.done}, 32'h0);
      wait_done(0, lat, bcyc);
      check($sformatf("v%0d_latency", i), lat, 32'd33);
      check($sformatf("v%0d_busy_cycles", i), bcyc, 32'd33);
      check($sformatf("v%0d_hi", i), bus.hi, vecs[i].hi);
      check($sformatf("v%0d_lo", i), bus.lo, vecs[i].lo);
    end

    // done is a single-cycle pulse and HI/LO hold afterwards.
    @(posedge clk);
    #1;
    check("done_pulse_end", {31'b0, bus.done}, 32'h0);
    check("idle_busy", {31'b0, bus.busy}, 32'h0);
    check("hold_hi", bus.hi, 32'hFFFF_FFFF);
    check("hold_lo", bus.lo, 32'h0000_0000);
    check("no_illegal_yet", illegal_cnt, 32'd0);

    // MTLO during MULT CALC is ignored; HI/LO keep old values until done.
    issue(OpMult, 32'h0000_0007, 32'hFFFF_FFFD);
    lat = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("calc_hi_old", bus.hi, 32'hFFFF_FFFF);
    check("calc_busy", {31'b0, bus.busy}, 32'h1);
    issue(OpMtlo, 32'h0000_DEAD, 32'h0);
    lat++;
    check("mtlo_ignored", bus.lo, 32'h0000_0000);
    wait_done(lat, lat, bdummy);
    check("busy_mtlo_latency", lat, 32'd33);
    check("busy_mtlo_hi", bus.hi, 32'hFFFF_FFFF);
    check("busy_mtlo_lo", bus.lo, 32'hFFFF_FFEB);
    check("illegal_seen", illegal_cnt, 32'd1);

    // Reset in the middle of a DIV aborts it and clears HI/LO at once.
    issue(OpDiv, 32'h0000_0064, 32'h0000_0007);
    repeat (9) @(posedge clk);
    #1;
    check("div_mid_busy", {31'b0, bus.busy}, 32'h1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_busy", {31'b0, bus.busy}, 32'h0);
    check("abort_done", {31'b0, bus.done}, 32'h0);
    check("abort_hi", bus.hi, 32'h0);
    check("abort_lo", bus.lo, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Fresh operation after reset release.
    issue(OpMult, 32'h0000_0003, 32'h0000_0004);
    wait_done(0, lat, bcyc);
    check("post_rst_latency", lat, 32'd33);
    check("post_rst_hi", bus.hi, 32'h0);
    check("post_rst_lo", bus.lo, 32'd12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net against a stuck run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d",
             checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
